// File: rtl/vector_dot_serial.sv
// vector_dot_serial
// Serial signed dot product of two LENGTH-element vectors. The block drives one
// shared element index to both vector registers, multiplies the two returned
// slices each cycle into a pipeline register and accumulates at full precision.
// The finished sum is offered to the consumer over a valid/ready handshake.
module vector_dot_serial #(
    parameter int SCALAR_BITS = 32,
    parameter int LENGTH      = 5
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    output logic                                        busy,
    output logic [$clog2(LENGTH)-1:0]                   read_index,
    input  logic [SCALAR_BITS-1:0]                      a_slice,
    input  logic [SCALAR_BITS-1:0]                      b_slice,
    output logic [2*SCALAR_BITS+$clog2(LENGTH)-1:0]     result,
    output logic                                        result_valid,
    input  logic                                        result_ready
);

    localparam int INDEX_WIDTH = $clog2(LENGTH);
    localparam int PROD_BITS   = 2 * SCALAR_BITS;
    localparam int ACC_BITS    = PROD_BITS + INDEX_WIDTH;
    localparam int EXT_BITS    = ACC_BITS - PROD_BITS;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Sign-extend a full-width product to accumulator width.
    function automatic logic [ACC_BITS-1:0] sext_prod(input logic [PROD_BITS-1:0] p);
        sext_prod = {{EXT_BITS{p[PROD_BITS-1]}}, p};
    endfunction

    state_t                   state_q,    state_d;
    logic [INDEX_WIDTH-1:0]   idx_q,      idx_d;
    logic [PROD_BITS-1:0]     prod_q,     prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic [ACC_BITS-1:0]      acc_q,      acc_d;

    logic [PROD_BITS-1:0]     a_ext_s;
    logic [PROD_BITS-1:0]     b_ext_s;
    logic [PROD_BITS-1:0]     mul_s;

    // Widen both operands to product width so the signed multiply is exact.
    always_comb begin
        a_ext_s = {{SCALAR_BITS{a_slice[SCALAR_BITS-1]}}, a_slice};
        b_ext_s = {{SCALAR_BITS{b_slice[SCALAR_BITS-1]}}, b_slice};
        mul_s   = PROD_BITS'($signed(a_ext_s) * $signed(b_ext_s));
    end

    // Next-state and datapath update for the IDLE/RUN/DRAIN/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        prod_d     = prod_q;
        prod_vld_d = prod_vld_q;
        acc_d      = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = {INDEX_WIDTH{1'b0}};
                    acc_d      = {ACC_BITS{1'b0}};
                    prod_vld_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                prod_d     = mul_s;
                prod_vld_d = 1'b1;
                // The product captured last cycle joins the sum one cycle late.
                if (prod_vld_q) begin
                    acc_d = acc_q + sext_prod(prod_q);
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_DRAIN: begin
                // Fold in the final product still sitting in the pipeline.
                acc_d      = acc_q + sext_prod(prod_q);
                prod_vld_d = 1'b0;
                state_d    = S_DONE;
            end
            S_DONE: begin
                // Start is deliberately not looked at here; a new job begins in IDLE.
                if (result_ready) begin
                    state_d = S_IDLE;
                    idx_d   = {INDEX_WIDTH{1'b0}};
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                idx_d      = {INDEX_WIDTH{1'b0}};
                prod_vld_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= {INDEX_WIDTH{1'b0}};
            prod_q     <= {PROD_BITS{1'b0}};
            prod_vld_q <= 1'b0;
            acc_q      <= {ACC_BITS{1'b0}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    // Outputs come straight from registers so they are glitch-free.
    always_comb begin
        busy         = (state_q != S_IDLE);
        read_index   = idx_q;
        result       = acc_q;
        result_valid = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_vector_dot_serial.sv
// Directed self-checking bench for vector_dot_serial (SCALAR_BITS=32, LENGTH=5).
// The two vector registers are modelled as small arrays read by read_index.
module tb_vector_dot_serial;

    localparam int SB  = 32;
    localparam int LEN = 5;
    localparam int IW  = 3;
    localparam int AW  = 2 * SB + IW;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic [IW-1:0]   read_index;
    logic [SB-1:0]   a_slice;
    logic [SB-1:0]   b_slice;
    logic [AW-1:0]   result;
    logic            result_valid;
    logic            result_ready;

    logic [SB-1:0]   a_mem [0:LEN-1];
    logic [SB-1:0]   b_mem [0:LEN-1];

    int pass_cnt;
    int total_cnt;

    vector_dot_serial #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .read_index   (read_index),
        .a_slice      (a_slice),
        .b_slice      (b_slice),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational slice read, as the vector registers provide.
    always_comb begin
        if (read_index < IW'(LEN)) begin
            a_slice = a_mem[read_index];
            b_slice = b_mem[read_index];
        end else begin
            a_slice = '0;
            b_slice = '0;
        end
    end

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [SB-1:0] a0, a1, a2, a3, a4,
                        input logic [SB-1:0] b0, b1, b2, b3, b4);
        a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3; a_mem[4] = a4;
        b_mem[0] = b0; b_mem[1] = b1; b_mem[2] = b2; b_mem[3] = b3; b_mem[4] = b4;
    endtask

    // One start pulse, index sequence, latency (valid 6 edges after the start edge),
    // result value, then accept.
    task automatic run_op(input string tag, input logic [AW-1:0] exp, input bit chk_idx);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, AW'(busy), AW'(1));
        n = 0;
        while (!result_valid && n < 20) begin
            if (chk_idx && n < LEN) chk({tag, "_idx"}, AW'(read_index), AW'(n));
            tick();
            n++;
        end
        chk({tag, "_lat"}, AW'(n), AW'(6));
        chk({tag, "_res"}, result, exp);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_idle"}, AW'({busy, result_valid}), AW'(0));
    endtask

    initial begin
        logic [AW-1:0] e;
        int n;
        int cyc;
        int last;
        int found;

        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        load(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #12;
        chk("rst_busy", AW'(busy), AW'(0));
        chk("rst_idx", AW'(read_index), AW'(0));
        chk("rst_res", result, AW'(0));
        chk("rst_vld", AW'(result_valid), AW'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: 1+2+3+4+5 = 15
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        run_op("t1", AW'(15), 1'b1);

        // Test 2: -12-14+0+5+12 = -9
        load(-32'sd3, 32'sd7, 32'sd0, -32'sd1, 32'sd2, 32'sd4, -32'sd2, 32'sd9, -32'sd5, 32'sd6);
        e = -AW'(9);
        run_op("t2", e, 1'b0);

        // Test 3a: five products of (-2^31)^2 = 5*2^62
        load(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        e = AW'(5) << 62;
        run_op("t3a", e, 1'b0);

        // Test 3b: 5*(2^31-1)*(-2^31) = -5*(2^62-2^31)
        load(32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        e = -((AW'(5) << 62) - (AW'(5) << 31));
        run_op("t3b", e, 1'b0);

        // Test 4: start pulses during RUN and DONE, backpressure for 10 cycles
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t4_vld", AW'(result_valid), AW'(1));
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
            chk("t4_hold_res", result, AW'(15));
            chk("t4_hold_vld", AW'({busy, result_valid}), AW'(3));
        end
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("t4_idle", AW'({busy, result_valid}), AW'(0));
        tick();
        tick();
        chk("t4_noqueue", AW'(busy), AW'(0));

        // Test 5: reset while RUN at idx=2, then rerun test 1
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_idx2", AW'(read_index), AW'(2));
        rst_n = 1'b0;
        #1;
        chk("t5_busy", AW'(busy), AW'(0));
        chk("t5_vld", AW'(result_valid), AW'(0));
        chk("t5_res", result, AW'(0));
        chk("t5_idx", AW'(read_index), AW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        run_op("t5_rerun", AW'(15), 1'b1);

        // Test 6: start and result_ready held high -> a result every LENGTH+3 cycles
        load(-32'sd3, 32'sd7, 32'sd0, -32'sd1, 32'sd2, 32'sd4, -32'sd2, 32'sd9, -32'sd5, 32'sd6);
        e = -AW'(9);
        start = 1'b1;
        result_ready = 1'b1;
        cyc = 0;
        last = -1;
        found = 0;
        while (found < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (result_valid) begin
                chk("t6_res", result, e);
                if (last >= 0) chk("t6_period", AW'(cyc - last), AW'(LEN + 3));
                last = cyc;
                found++;
            end
        end
        start = 1'b0;
        chk("t6_count", AW'(found), AW'(3));
        tick();
        result_ready = 1'b0;
        tick();
        chk("t6_idle", AW'(busy), AW'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
